pipeline_hazard_ctrl: RTL

- Central hazard and sequencing controller for the 5-stage pipeline (PC, BF0 IF/ID, BF1 ID/EX, BF2 EX/MEM, BF3 MEM/WB).
- Generates PC and buffer write-enables, flushes, bubble insertion, a global freeze for slow data-memory accesses, and forwarding selects for the ALU operands.
- Runs a post-reset pipeline-clear sequence, because the stage buffers have no reset of their own.
- Keeps saturating stall and flush statistics.

---
 rtl/pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Sequences a post-reset pipeline clear, resolves memory-wait freezes,
// taken-branch flushes and load-use bubbles in priority order, selects
// ALU operand forwarding, and keeps saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_CPU,
  input  logic             rst_n_CPU,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic [4:0]       rs_EX,
  input  logic [4:0]       rt_EX,
  input  logic             memRead_EX,
  input  logic             regWrite_MEM,
  input  logic [4:0]       wAddr_MEM,
  input  logic             regWrite_WB,
  input  logic [4:0]       wAddr_WB,
  input  logic             branchTaken_MEM,
  input  logic             memAccess_MEM,
  input  logic             memAck,
  output logic             pcWrite,
  output logic             bf0Write,
  output logic             bf0Flush,
  output logic             bf1Flush,
  output logic             bf2Flush,
  output logic             bf1Bubble,
  output logic             freeze,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic decode_live;
  logic load_use;
  logic mem_stall;
  logic take_branch;
  logic take_load_use;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Forwarding source for one operand; the younger MEM result wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       wr_mem,
                                         input logic [4:0] addr_mem,
                                         input logic       wr_wb,
                                         input logic [4:0] addr_wb);
    if (wr_mem && (addr_mem != 5'd0) && (addr_mem == src))
      return 2'b10;
    else if (wr_wb && (addr_wb != 5'd0) && (addr_wb == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Hazard qualifiers; the priority order memory > branch > load-use is resolved here.
  always_comb begin
    decode_live   = (state == S_RUN) || (state == S_MEM_WAIT);
    load_use      = memRead_EX && (rt_EX != 5'd0) &&
                    ((rt_EX == rs_ID) || (rt_EX == rt_ID));
    mem_stall     = ((state == S_RUN) && memAccess_MEM && !memAck) ||
                    ((state == S_MEM_WAIT) && !memAck);
    take_branch   = decode_live && !mem_stall && branchTaken_MEM;
    take_load_use = decode_live && !mem_stall && !branchTaken_MEM && load_use;
  end

  // State register plus sequencing counters, sticky error flag and statistics.
  always_ff @(posedge clk_CPU or negedge rst_n_CPU) begin
    if (!rst_n_CPU) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      wait_cnt   <= '0;
      memTimeout <= 1'b0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT)
        init_cnt <= init_cnt + 1'b1;
      if ((state == S_RUN) && mem_stall)
        wait_cnt <= WAIT_W'(1);
      else if ((state == S_MEM_WAIT) && memAck)
        wait_cnt <= '0;
      else if ((state == S_MEM_WAIT) && (wait_cnt != WAIT_W'(MEM_TIMEOUT)))
        wait_cnt <= wait_cnt + 1'b1;
      if (state_nxt == S_ERROR)
        memTimeout <= 1'b1;
      if (mem_stall || take_load_use)
        stallCount <= sat_inc(stallCount);
      if (take_branch)
        flushCount <= sat_inc(flushCount);
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = S_RUN;
      S_RUN:      if (mem_stall) state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (memAck)
          state_nxt = S_RUN;
        else if (wait_cnt == WAIT_W'(MEM_TIMEOUT))
          state_nxt = S_ERROR;
      end
      default:    state_nxt = S_ERROR;
    endcase
  end

  // Pipeline control decode (Mealy in RUN and on the MEM_WAIT ack cycle).
  always_comb begin
    pcWrite   = 1'b0;
    bf0Write  = 1'b0;
    bf0Flush  = 1'b0;
    bf1Flush  = 1'b0;
    bf2Flush  = 1'b0;
    bf1Bubble = 1'b0;
    freeze    = 1'b0;
    case (state)
      S_INIT: begin
        bf0Flush  = 1'b1;
        bf1Flush  = 1'b1;
        bf2Flush  = 1'b1;
        bf1Bubble = 1'b1;
      end
      S_RUN, S_MEM_WAIT: begin
        if (mem_stall) begin
          freeze = 1'b1;
        end else begin
          pcWrite  = 1'b1;
          bf0Write = 1'b1;
          if (take_branch) begin
            bf0Flush = 1'b1;
            bf1Flush = 1'b1;
            bf2Flush = 1'b1;
          end else if (take_load_use) begin
            pcWrite   = 1'b0;
            bf0Write  = 1'b0;
            bf1Bubble = 1'b1;
          end
        end
      end
      default: freeze = 1'b1;
    endcase
  end

  // Operand forwarding selects; held at the register path while the pipeline clears.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (state != S_INIT) begin
      fwdA = fwd_sel(rs_EX, regWrite_MEM, wAddr_MEM, regWrite_WB, wAddr_WB);
      fwdB = fwd_sel(rt_EX, regWrite_MEM, wAddr_MEM, regWrite_WB, wAddr_WB);
    end
  end

endmodule
